fog_sq_demod_accum: RTL and testbench

- Synchronous square-wave demodulator; sits directly downstream of the square-wave modulation generator in the HINS closed-loop path.
- Consumes the generator's status and step-trigger outputs together with the ADC sample stream.
- Per half-period: discards settling samples, accumulates the remaining samples per polarity, then emits one signed error word per full modulation period: sum over the HIGH half minus sum over the LOW half.

---
 rtl/fog_demod_pkg.sv | 31 +++
 rtl/fog_half_accum.sv | 103 ++++++++++
 rtl/fog_sq_demod_accum.sv | 139 +++++++++++++
 tb/tb_fog_sq_demod_accum.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fog_demod_pkg.sv
// Shared types, default widths and the saturation helper for the
// square-wave demodulator.
//   demod_state_e : IDLE / SKIP / ACCUM sequencing states
//   sat_signed()  : clamps a sign-extended SAT_W-bit value to out_w bits
package fog_demod_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, ACCUM} demod_state_e;

  localparam int ADC_W_DEF = 14;
  localparam int ACC_W_DEF = 40;
  localparam int OUT_W_DEF = 32;
  localparam int SKIP_W    = 16;
  localparam int CNT_W     = 16;
  // Working width for the saturation helper; must hold ACC_W+1 bits.
  localparam int SAT_W     = 64;

  // Clamp x to [-2^(out_w-1), 2^(out_w-1)-1]. The caller sign-extends its
  // ACC_W+1 difference into SAT_W bits and keeps the low out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/fog_half_accum.sv
// Per-half-period skip counter and accumulator.
//   clr_i        : synchronous clear of everything (demodulator disabled)
//   load_i       : step pulse; reload skip count, restart acc (a coincident
//                  valid sample already belongs to the new half)
//   active_i     : accumulate/skip samples (SKIP or ACCUM state)
//   skip_cnt_i   : samples to discard after each step
//   adc_data_i / adc_valid_i : sample stream
//   acc_o        : running half-period sum
//   skip_zero_o  : settling samples exhausted
//   cnt_o        : accumulated sample count (FOG_DEMOD_SAMPLE_CNT_EN only)
module fog_half_accum
  import fog_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    active_i,
  input  logic [SKIP_W-1:0]       skip_cnt_i,
  input  logic signed [ADC_W-1:0] adc_data_i,
  input  logic                    adc_valid_i,
  output logic signed [ACC_W-1:0] acc_o,
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  output logic [CNT_W-1:0]        cnt_o,
`endif
  output logic                    skip_zero_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, samp_ext;
  logic [SKIP_W-1:0]       skip_q, skip_d;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  assign samp_ext = {{(ACC_W-ADC_W){adc_data_i[ADC_W-1]}}, adc_data_i};

  always_comb begin
    acc_d  = acc_q;
    skip_d = skip_q;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    cnt_d  = cnt_q;
`endif
    if (clr_i) begin
      acc_d  = '0;
      skip_d = '0;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
      cnt_d  = '0;
`endif
    end else if (load_i) begin
      acc_d  = '0;
      skip_d = skip_cnt_i;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
      cnt_d  = '0;
`endif
      if (adc_valid_i) begin
        if (skip_cnt_i == '0) begin
          acc_d = samp_ext;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
          cnt_d = CNT_W'(1);
`endif
        end else begin
          skip_d = skip_cnt_i - 1'b1;
        end
      end
    end else if (active_i && adc_valid_i) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        // Wraps silently beyond ACC_W; sized for >= 2^24 samples per half.
        acc_d = acc_q + samp_ext;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      skip_q <= '0;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      acc_q  <= acc_d;
      skip_q <= skip_d;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign acc_o       = acc_q;
  assign skip_zero_o = (skip_q == '0);
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  assign cnt_o       = cnt_q;
`endif

endmodule

// File: rtl/fog_sq_demod_accum.sv
// Synchronous square-wave demodulator. Accumulates ADC samples per
// modulation half (after discarding settling samples) and emits
// sat(sum_HIGH - sum_LOW) once per full period, one cycle after the
// LOW-ending step pulse.
//   i_clk, i_rst_n (async, active-low)
//   i_en          : low forces IDLE and clears accumulators/flags
//   i_adc_data/i_adc_valid : signed sample stream
//   i_status      : polarity of the half that is running (1 = HIGH)
//   i_stepTrig    : end-of-half pulse; i_status still shows the ending half
//   i_skip_cnt    : settling samples discarded after each step
//   o_err/o_err_valid : saturated error word and its one-cycle strobe
//   o_sat         : sticky saturation flag
//   o_nH/o_nL     : per-half sample counts, only with FOG_DEMOD_SAMPLE_CNT_EN
// Requires ACC_W >= ADC_W+24 and ACC_W+1 <= 64.
module fog_sq_demod_accum
  import fog_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic signed [ADC_W-1:0] i_adc_data,
  input  logic                    i_adc_valid,
  input  logic                    i_status,
  input  logic                    i_stepTrig,
  input  logic [SKIP_W-1:0]       i_skip_cnt,
  output logic signed [OUT_W-1:0] o_err,
  output logic                    o_err_valid,
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  output logic [CNT_W-1:0]        o_nH,
  output logic [CNT_W-1:0]        o_nL,
`endif
  output logic                    o_sat
);

  demod_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc, sum_h_q;
  logic                    skip_zero, h_valid_q;
  logic signed [ACC_W:0]   diff;
  logic signed [SAT_W-1:0] diff_wide, clamped;
  logic signed [OUT_W-1:0] err_q;
  logic                    err_vld_q, sat_q, clip, close;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  logic [CNT_W-1:0]        cnt, nh_hold_q, nh_q, nl_q;
`endif

  // A step while enabled always restarts the half accumulator; it only
  // closes a half (and may emit) once we are past IDLE.
  assign close = i_en && i_stepTrig && (state_q != IDLE);

  fog_half_accum #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_half (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .clr_i       (!i_en),
    .load_i      (i_en && i_stepTrig),
    .active_i    (i_en && (state_q != IDLE)),
    .skip_cnt_i  (i_skip_cnt),
    .adc_data_i  (i_adc_data),
    .adc_valid_i (i_adc_valid),
    .acc_o       (acc),
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    .cnt_o       (cnt),
`endif
    .skip_zero_o (skip_zero)
  );

  always_comb begin
    state_d = state_q;
    if (!i_en)           state_d = IDLE;
    else if (i_stepTrig) state_d = SKIP;
    else if (state_q == SKIP && i_adc_valid && skip_zero) state_d = ACCUM;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // HIGH minus LOW at ACC_W+1 bits, then clamp to OUT_W.
  always_comb begin
    diff      = {sum_h_q[ACC_W-1], sum_h_q} - {acc[ACC_W-1], acc};
    diff_wide = {{(SAT_W-ACC_W-1){diff[ACC_W]}}, diff};
    clamped   = sat_signed(diff_wide, OUT_W);
    clip      = (clamped != diff_wide);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_h_q   <= '0;
      h_valid_q <= 1'b0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
      sat_q     <= 1'b0;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
      nh_hold_q <= '0;
      nh_q      <= '0;
      nl_q      <= '0;
`endif
    end else begin
      err_vld_q <= 1'b0;
      if (!i_en) begin
        // o_err (and the counts) hold their last value while disabled.
        sum_h_q   <= '0;
        h_valid_q <= 1'b0;
        sat_q     <= 1'b0;
      end else if (close) begin
        if (i_status) begin
          sum_h_q   <= acc;
          h_valid_q <= 1'b1;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
          nh_hold_q <= cnt;
`endif
        end else if (h_valid_q) begin
          err_q     <= clamped[OUT_W-1:0];
          err_vld_q <= 1'b1;
          sat_q     <= sat_q | clip;
          h_valid_q <= 1'b0;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
          nh_q      <= nh_hold_q;
          nl_q      <= cnt;
`endif
        end
      end
    end
  end

  assign o_err       = err_q;
  assign o_err_valid = err_vld_q;
  assign o_sat       = sat_q;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  assign o_nH        = nh_q;
  assign o_nL        = nl_q;
`endif

endmodule

// File: tb/tb_fog_sq_demod_accum.sv
// Directed bench for fog_sq_demod_accum (OUT_W=16 so saturation is
// reachable with 14-bit samples). Count checks are compiled in when
// FOG_DEMOD_SAMPLE_CNT_EN is defined.
module tb_fog_sq_demod_accum;
  localparam int ADC_W = 14;
  localparam int ACC_W = 40;
  localparam int OUT_W = 16;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_en;
  logic signed [ADC_W-1:0] i_adc_data;
  logic                    i_adc_valid;
  logic                    i_status;
  logic                    i_stepTrig;
  logic [15:0]             i_skip_cnt;
  logic signed [OUT_W-1:0] o_err;
  logic                    o_err_valid;
  logic                    o_sat;
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
  logic [15:0]             o_nH, o_nL;
`endif

  int n_chk = 0;
  int n_err = 0;

  fog_sq_demod_accum #(.ADC_W(ADC_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_adc_data  (i_adc_data),
    .i_adc_valid (i_adc_valid),
    .i_status    (i_status),
    .i_stepTrig  (i_stepTrig),
    .i_skip_cnt  (i_skip_cnt),
    .o_err       (o_err),
    .o_err_valid (o_err_valid),
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    .o_nH        (o_nH),
    .o_nL        (o_nL),
`endif
    .o_sat       (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One modulation half: n valid samples of value v, then the step cycle
  // (optionally carrying a coincident sample cval). Checks the strobe
  // one cycle after the step, and the error word when one is expected.
  task automatic half(input bit st, input int n, input int v, input bit cv,
                      input int cval, input bit ev, input int ee,
                      input string tag);
    i_status = st;
    for (int i = 0; i < n; i++) begin
      i_adc_valid = 1'b1;
      i_adc_data  = ADC_W'(v);
      tick();
    end
    i_adc_valid = cv;
    i_adc_data  = ADC_W'(cval);
    i_stepTrig  = 1'b1;
    tick();
    i_stepTrig  = 1'b0;
    i_adc_valid = 1'b0;
    chk({tag, "_vld"}, o_err_valid, ev);
    if (ev) chk({tag, "_err"}, o_err, ee);
  endtask

  // Disable for a cycle, then re-arm from IDLE with a new skip count.
  task automatic restart(input int skip);
    i_en        = 1'b0;
    i_adc_valid = 1'b0;
    tick();
    i_en       = 1'b1;
    i_skip_cnt = 16'(skip);
    half(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, "prime");
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_adc_data = '0; i_adc_valid = 1'b0;
    i_status = 1'b0; i_stepTrig = 1'b0; i_skip_cnt = '0;
    tick(); tick();
    chk("rst_err", o_err, 0);
    chk("rst_vld", o_err_valid, 0);
    chk("rst_sat", o_sat, 0);
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    chk("rst_nH", o_nH, 0);
    chk("rst_nL", o_nL, 0);
`endif
    i_rst_n = 1'b1;
    tick();

    // Constant 100, 10 per half, skip 2: partial half discarded, leading
    // LOW discarded, then zero each full period.
    i_en = 1'b1; i_skip_cnt = 16'd2;
    half(1'b1, 5, 100, 1'b0, 0, 1'b0, 0, "c_part");
    half(1'b0, 10, 100, 1'b0, 0, 1'b0, 0, "c_lo0");
    half(1'b1, 10, 100, 1'b0, 0, 1'b0, 0, "c_hi1");
    half(1'b0, 10, 100, 1'b0, 0, 1'b1, 0, "c_lo1");
    half(1'b1, 10, 100, 1'b0, 0, 1'b0, 0, "c_hi2");
    half(1'b0, 10, 100, 1'b0, 0, 1'b1, 0, "c_lo2");

    // 500 / -300, 8 per half, skip 3: 5*500 + 5*300 = 4000.
    restart(3);
    half(1'b1, 8, 500, 1'b0, 0, 1'b0, 0, "p_hi");
    half(1'b0, 8, -300, 1'b0, 0, 1'b1, 4000, "p_lo");
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    chk("p_nH", o_nH, 5);
    chk("p_nL", o_nL, 5);
`endif

    // 12 per half, skip 4: 8 counted each side, 80 - (-80) = 160.
    restart(4);
    half(1'b1, 12, 10, 1'b0, 0, 1'b0, 0, "n_hi");
    half(1'b0, 12, -10, 1'b0, 0, 1'b1, 160, "n_lo");
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    chk("n_nH", o_nH, 8);
    chk("n_nL", o_nL, 8);
`endif

    // Saturation: 81910 + 81920 clamps to 32767; sticky; i_en low clears.
    restart(0);
    half(1'b1, 10, 8191, 1'b0, 0, 1'b0, 0, "s_hi1");
    half(1'b0, 10, -8192, 1'b0, 0, 1'b1, 32767, "s_lo1");
    chk("s_sat1", o_sat, 1);
    half(1'b1, 10, 8191, 1'b0, 0, 1'b0, 0, "s_hi2");
    half(1'b0, 10, -8192, 1'b0, 0, 1'b1, 32767, "s_lo2");
    chk("s_sat2", o_sat, 1);
    i_en = 1'b0;
    tick();
    chk("s_sat_clr", o_sat, 0);
    chk("s_err_hold", o_err, 32767);

    // Skip exceeds samples: each half contributes 0.
    restart(20);
    half(1'b1, 8, 100, 1'b0, 0, 1'b0, 0, "k_hi1");
    half(1'b0, 8, 50, 1'b0, 0, 1'b1, 0, "k_lo1");
    half(1'b1, 8, 100, 1'b0, 0, 1'b0, 0, "k_hi2");
    half(1'b0, 8, 50, 1'b0, 0, 1'b1, 0, "k_lo2");

    // Coincident sample with skip 0 opens the LOW sum: 21 - 1020 = -999.
    restart(0);
    half(1'b1, 3, 7, 1'b1, 1000, 1'b0, 0, "x_hi");
    half(1'b0, 2, 10, 1'b0, 0, 1'b1, -999, "x_lo");

    // Enable dropped mid-HIGH: no pulse, value held, and the next output
    // needs a fresh HIGH then LOW.
    restart(0);
    half(1'b1, 4, 100, 1'b0, 0, 1'b0, 0, "e_hi0");
    half(1'b0, 4, -20, 1'b0, 0, 1'b1, 480, "e_lo0");
    i_status = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_adc_valid = 1'b1; i_adc_data = ADC_W'(100); tick();
    end
    i_en = 1'b0; i_adc_valid = 1'b0;
    tick();
    chk("e_drop_vld", o_err_valid, 0);
    chk("e_drop_hold", o_err, 480);
    i_en = 1'b1;
    half(1'b1, 2, 100, 1'b0, 0, 1'b0, 0, "e_hi1");
    half(1'b0, 4, -20, 1'b0, 0, 1'b0, 0, "e_lo1");
    half(1'b1, 4, 50, 1'b0, 0, 1'b0, 0, "e_hi2");
    half(1'b0, 4, -20, 1'b0, 0, 1'b1, 280, "e_lo2");

    // Async reset mid-ACCUM with a saturated, nonzero output pending.
    restart(0);
    half(1'b1, 10, 8191, 1'b0, 0, 1'b0, 0, "r_hi");
    half(1'b0, 10, -8192, 1'b0, 0, 1'b1, 32767, "r_lo");
    chk("r_sat_pre", o_sat, 1);
    i_status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_adc_valid = 1'b1; i_adc_data = ADC_W'(100); tick();
    end
    i_rst_n = 1'b0;
    #2;
    chk("r_err", o_err, 0);
    chk("r_vld", o_err_valid, 0);
    chk("r_sat", o_sat, 0);
`ifdef FOG_DEMOD_SAMPLE_CNT_EN
    chk("r_nH", o_nH, 0);
    chk("r_nL", o_nL, 0);
`endif
    i_adc_valid = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
